// File: rtl/sha256_round_ctrl.sv
// ============================================================================
// Module   : sha256_round_ctrl
// Purpose  : Sequences the SHA-256 compression datapath. It accepts message
//            blocks, steps the round counter, and raises the H-init and
//            H-update strobes and the digest flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_round_ctrl #(
    parameter int ROUNDS      = 64,
    parameter int SCHED_START = 16,
    parameter int RW          = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          msg_valid,
    input  logic          msg_first,
    input  logic          msg_last,
    output logic          msg_ready,
    input  logic          abort,
    input  logic          digest_ack,
    output logic          h_init,
    output logic          load_work,
    output logic          round_en,
    output logic [RW-1:0] round_idx,
    output logic          w_sel,
    output logic          h_update,
    output logic          busy,
    output logic          digest_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROUND  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    localparam logic [RW-1:0] C_LAST_IDX  = RW'(ROUNDS - 1);
    localparam logic [RW-1:0] C_SCHED_IDX = RW'(SCHED_START);

    state_t        state_q;
    logic [RW-1:0] idx_q;
    logic          chain_q;
    logic          last_q;
    logic          dv_q;

    logic w_accept;
    logic w_init;

    // abort has priority, so a block offered in the abort cycle is refused
    assign w_accept = (state_q == S_IDLE) && msg_valid && !abort;
    assign w_init   = w_accept && (msg_first || !chain_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            chain_q <= 1'b0;
            last_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else if (abort) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            chain_q <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            if (digest_ack) begin
                dv_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        last_q  <= msg_last;
                        state_q <= S_LOAD;
                        if (w_init) begin
                            dv_q <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    idx_q   <= '0;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    // Counter parks on the last round; UPDATE clears it.
                    if (idx_q == C_LAST_IDX) begin
                        state_q <= S_UPDATE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_UPDATE: begin
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                    if (last_q) begin
                        dv_q    <= 1'b1;
                        chain_q <= 1'b0;
                    end else begin
                        chain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign msg_ready    = (state_q == S_IDLE);
    assign h_init       = w_init;
    assign load_work    = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign round_en     = (state_q == S_ROUND);
    assign round_idx    = idx_q;
    assign w_sel        = (state_q == S_ROUND) && (idx_q >= C_SCHED_IDX);
    assign h_update     = (state_q == S_UPDATE);
    assign busy         = (state_q != S_IDLE);
    assign digest_valid = dv_q;

endmodule

`default_nettype wire
